// File: rtl/pipe_elastic_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_elastic_reg_pkg
//   Shared definitions for the elastic inter-stage register:
//   - stage_state_e : occupancy state of one 2-entry skid stage
//   - default bundle widths and the maximum supported chain depth
//   - LOW/HIGH/CLEAR constants used for readable constant drives
//   - occ_width_ok  : true when an occupancy counter of the given width can
//                     represent every value 0..2*depth
// -----------------------------------------------------------------------------
package pipe_elastic_reg_pkg;

  // Stage state: how many entries a skid stage currently holds.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  localparam int DEFAULT_PIPE_CTRL_WIDTH = 8;
  localparam int DEFAULT_PIPE_DATA_WIDTH = 32;
  localparam int MAX_PIPE_DEPTH          = 4;

  localparam logic LOW   = 1'b0;
  localparam logic HIGH  = 1'b1;
  localparam logic CLEAR = 1'b0;

  // Each stage holds at most two items, so the counter must reach 2*depth.
  function automatic bit occ_width_ok(input int depth, input int occ_width);
    return (2 ** occ_width) > (2 * depth);
  endfunction

endpackage : pipe_elastic_reg_pkg

// File: rtl/pipe_elastic_reg_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_elastic_reg_skid_stage (logical name: pipe_skid_stage)
//   One elastic pipeline stage: a main register (the head presented
//   downstream) plus a skid register that absorbs the one extra item that can
//   arrive in the cycle the downstream side stalls. up_ready depends only on
//   the stage state, so chaining stages never builds a combinational ready
//   path.
//
// Ports:
//   clk, srst          clock and synchronous active-high reset
//   flush              drop all held items, control registers cleared
//   enable             low = freeze (no state, data or handshake activity)
//   up_valid/up_ready  upstream handshake, up_ctrl/up_data upstream bundle
//   dn_valid/dn_ready  downstream handshake, dn_ctrl/dn_data head bundle
// -----------------------------------------------------------------------------
module pipe_elastic_reg_skid_stage
  import pipe_elastic_reg_pkg::*;
#(
  parameter int CTRL_WIDTH = DEFAULT_PIPE_CTRL_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_PIPE_DATA_WIDTH,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  flush,
  input  logic                  enable,
  input  logic                  up_valid,
  output logic                  up_ready,
  input  logic [CTRL_WIDTH-1:0] up_ctrl,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  dn_valid,
  input  logic                  dn_ready,
  output logic [CTRL_WIDTH-1:0] dn_ctrl,
  output logic [DATA_WIDTH-1:0] dn_data
);

  stage_state_e          state_reg, state_next;
  logic [CTRL_WIDTH-1:0] main_ctrl_reg, main_ctrl_next;
  logic [CTRL_WIDTH-1:0] skid_ctrl_reg, skid_ctrl_next;
  logic [DATA_WIDTH-1:0] main_data_reg, main_data_next;
  logic [DATA_WIDTH-1:0] skid_data_reg, skid_data_next;
  logic                  up_fire;
  logic                  dn_fire;

  assign up_ready = (state_reg != ST_TWO);
  assign dn_valid = (state_reg != ST_EMPTY);
  assign dn_ctrl  = main_ctrl_reg;
  assign dn_data  = main_data_reg;

  // Fires are qualified by enable so a frozen pipe cannot move items even
  // between its own internal stages.
  assign up_fire = enable & up_valid & up_ready;
  assign dn_fire = enable & dn_valid & dn_ready;

  always_comb begin
    state_next     = state_reg;
    main_ctrl_next = main_ctrl_reg;
    skid_ctrl_next = skid_ctrl_reg;
    main_data_next = main_data_reg;
    skid_data_next = skid_data_reg;

    case (state_reg)
      ST_EMPTY: begin
        if (up_fire) begin
          state_next     = ST_ONE;
          main_ctrl_next = up_ctrl;
          main_data_next = up_data;
        end
      end
      ST_ONE: begin
        if (up_fire && dn_fire) begin
          // Pass-through: head leaves, new item becomes head.
          main_ctrl_next = up_ctrl;
          main_data_next = up_data;
        end else if (up_fire) begin
          // Downstream stalled: park the new item in the skid register.
          state_next     = ST_TWO;
          skid_ctrl_next = up_ctrl;
          skid_data_next = up_data;
        end else if (dn_fire) begin
          state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // Not ready in this state, so only a departure can happen.
        if (dn_fire) begin
          state_next     = ST_ONE;
          main_ctrl_next = skid_ctrl_reg;
          main_data_next = skid_data_reg;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase

    // Flush overrides the handshake and ignores enable; an item offered in
    // the same cycle is dropped without touching the data registers unless
    // they are configured to clear.
    if (flush) begin
      state_next     = ST_EMPTY;
      main_ctrl_next = '0;
      skid_ctrl_next = '0;
      main_data_next = CLEAR_DATA ? '0 : main_data_reg;
      skid_data_next = CLEAR_DATA ? '0 : skid_data_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg     <= ST_EMPTY;
      main_ctrl_reg <= '0;
      skid_ctrl_reg <= '0;
    end else begin
      state_reg     <= state_next;
      main_ctrl_reg <= main_ctrl_next;
      skid_ctrl_reg <= skid_ctrl_next;
    end
  end

  // Data registers only clear on reset when configured to; otherwise reset
  // leaves them holding their last value.
  always_ff @(posedge clk) begin
    if (srst) begin
      if (CLEAR_DATA) begin
        main_data_reg <= '0;
        skid_data_reg <= '0;
      end
    end else begin
      main_data_reg <= main_data_next;
      skid_data_reg <= skid_data_next;
    end
  end

endmodule : pipe_elastic_reg_skid_stage

// File: rtl/pipe_elastic_reg.sv
// -----------------------------------------------------------------------------
// pipe_elastic_reg
//   Parametrised elastic pipeline register placed between two pipeline
//   stages. DEPTH chained 2-entry skid stages carry a control bundle and a
//   data bundle with a valid/ready handshake, flush (control forced to zero =
//   NOP), a global enable freeze and an occupancy count.
//
// Parameters:
//   CTRL_WIDTH  control bundle width (flush/reset force it to zero)
//   DATA_WIDTH  data bundle width
//   DEPTH       number of chained stages, 1..MAX_PIPE_DEPTH
//   CLEAR_DATA  1 = flush and reset also zero the data registers
//   OCC_WIDTH   occupancy width, needs 2**OCC_WIDTH > 2*DEPTH
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_enable              global advance enable (low = freeze)
//   i_flush               drop every held item
//   i_valid/o_ready       upstream handshake, i_ctrl/i_data upstream bundle
//   o_valid/i_ready       downstream handshake, o_ctrl/o_data head bundle
//   o_occupancy, o_empty  items currently held, and occupancy == 0
// -----------------------------------------------------------------------------
module pipe_elastic_reg
  import pipe_elastic_reg_pkg::*;
#(
  parameter int CTRL_WIDTH = DEFAULT_PIPE_CTRL_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_PIPE_DATA_WIDTH,
  parameter int DEPTH      = 1,
  parameter int CLEAR_DATA = 0,
  parameter int OCC_WIDTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [CTRL_WIDTH-1:0] o_ctrl,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [OCC_WIDTH-1:0]  o_occupancy,
  output logic                  o_empty
);

  localparam bit                   CLEAR_DATA_BIT = (CLEAR_DATA != 0);
  localparam logic [OCC_WIDTH-1:0] OCC_ONE        = OCC_WIDTH'(1);

  // Link k is the interface into stage k; link DEPTH is the block output.
  logic [DEPTH:0]        link_valid;
  logic [DEPTH:0]        link_ready;
  logic [CTRL_WIDTH-1:0] link_ctrl [0:DEPTH];
  logic [DATA_WIDTH-1:0] link_data [0:DEPTH];

  logic                  in_fire;
  logic                  out_fire;
  logic [OCC_WIDTH-1:0]  occ_reg, occ_next;

  assign link_valid[0]     = i_valid;
  assign link_ctrl[0]      = i_ctrl;
  assign link_data[0]      = i_data;
  assign link_ready[DEPTH] = i_ready;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      pipe_elastic_reg_skid_stage #(
        .CTRL_WIDTH (CTRL_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CLEAR_DATA (CLEAR_DATA_BIT)
      ) u_stage (
        .clk      (i_clk),
        .srst     (i_reset),
        .flush    (i_flush),
        .enable   (i_enable),
        .up_valid (link_valid[gi]),
        .up_ready (link_ready[gi]),
        .up_ctrl  (link_ctrl[gi]),
        .up_data  (link_data[gi]),
        .dn_valid (link_valid[gi+1]),
        .dn_ready (link_ready[gi+1]),
        .dn_ctrl  (link_ctrl[gi+1]),
        .dn_data  (link_data[gi+1])
      );
    end
  endgenerate

  // Freeze hides both handshakes so neither neighbour can see a fire.
  assign o_ready = i_enable ? link_ready[0]     : LOW;
  assign o_valid = i_enable ? link_valid[DEPTH] : LOW;
  assign o_ctrl  = link_ctrl[DEPTH];
  assign o_data  = link_data[DEPTH];

  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  // Occupancy tracks the handshakes directly; a simultaneous arrival and
  // departure leaves it unchanged.
  always_comb begin
    occ_next = occ_reg;
    if (i_flush) begin
      occ_next = '0;
    end else if (in_fire && !out_fire) begin
      occ_next = occ_reg + OCC_ONE;
    end else if (!in_fire && out_fire) begin
      occ_next = occ_reg - OCC_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_next;
    end
  end

  assign o_occupancy = occ_reg;
  assign o_empty     = (occ_reg == '0) ? HIGH : CLEAR;

endmodule : pipe_elastic_reg

// File: tb/tb_pipe_elastic_reg.sv
module tb_pipe_elastic_reg;

  typedef struct packed {
    logic [7:0]  c;
    logic [31:0] d;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, flush, valid, ready;
  logic [7:0]  ctrl;
  logic [31:0] data;

  // DUT a: DEPTH=2, CLEAR_DATA=1.  DUT b: DEPTH=1, CLEAR_DATA=0.
  logic        a_ready, a_valid, a_empty, b_ready, b_valid, b_empty;
  logic [7:0]  a_ctrl, b_ctrl;
  logic [31:0] a_data, b_data;
  logic [3:0]  a_occ, b_occ;

  pipe_elastic_reg #(.CTRL_WIDTH(8), .DATA_WIDTH(32), .DEPTH(2), .CLEAR_DATA(1), .OCC_WIDTH(4)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_flush(flush),
    .i_valid(valid), .o_ready(a_ready), .i_ctrl(ctrl), .i_data(data),
    .o_valid(a_valid), .i_ready(ready), .o_ctrl(a_ctrl), .o_data(a_data),
    .o_occupancy(a_occ), .o_empty(a_empty));

  pipe_elastic_reg #(.CTRL_WIDTH(8), .DATA_WIDTH(32), .DEPTH(1), .CLEAR_DATA(0), .OCC_WIDTH(4)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_flush(flush),
    .i_valid(valid), .o_ready(b_ready), .i_ctrl(ctrl), .i_data(data),
    .o_valid(b_valid), .i_ready(ready), .o_ctrl(b_ctrl), .o_data(b_data),
    .o_occupancy(b_occ), .o_empty(b_empty));

  int checks = 0;
  int passes = 0;

  // Reference model: one FIFO of accepted items per DUT.
  item_t qa[$];
  item_t qb[$];

  // Per-cycle samples (taken at the falling edge) and model expectations.
  logic        a_s_valid, a_s_ready, a_s_empty, b_s_valid, b_s_ready, b_s_empty;
  logic [7:0]  a_s_ctrl, b_s_ctrl;
  logic [31:0] a_s_data, b_s_data;
  logic [3:0]  a_s_occ, b_s_occ;
  int          a_occ_exp, b_occ_exp;
  logic        a_in_f, a_out_f, b_in_f, b_out_f;
  bit          a_pop_ok, b_pop_ok;
  item_t       a_exp, b_exp;

  // One clock cycle: sample outputs, update the model, cross the edge.
  task automatic tick();
    @(negedge clk);
    a_s_valid = a_valid; a_s_ready = a_ready; a_s_ctrl = a_ctrl;
    a_s_data = a_data; a_s_occ = a_occ; a_s_empty = a_empty;
    b_s_valid = b_valid; b_s_ready = b_ready; b_s_ctrl = b_ctrl;
    b_s_data = b_data; b_s_occ = b_occ; b_s_empty = b_empty;
    a_occ_exp = qa.size();
    b_occ_exp = qb.size();
    a_in_f  = valid & a_ready;
    a_out_f = a_valid & ready;
    b_in_f  = valid & b_ready;
    b_out_f = b_valid & ready;
    a_pop_ok = 1'b0; a_exp = '0;
    b_pop_ok = 1'b0; b_exp = '0;
    if (a_out_f === 1'b1 && qa.size() > 0) begin a_exp = qa.pop_front(); a_pop_ok = 1'b1; end
    if (b_out_f === 1'b1 && qb.size() > 0) begin b_exp = qb.pop_front(); b_pop_ok = 1'b1; end
    if (a_out_f === 1'b1) $display("%0t a_out ctrl=%02h data=%08h occ=%0d", $time, a_ctrl, a_data, a_occ);
    if (a_in_f === 1'b1) qa.push_back(item_t'{c: ctrl, d: data});
    if (b_in_f === 1'b1) qb.push_back(item_t'{c: ctrl, d: data});
    if (reset || flush) begin
      qa.delete();
      qb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; enable = 1'b1; valid = 1'b0; ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; enable = 1'b1; valid = 1'b1; ready = 1'b0;
    ctrl = 8'hFF; data = 32'hFFFF_FFFF;
    tick();
    tick();
    reset = 1'b0; valid = 1'b0;
    checks++; if (a_valid !== 1'b0) $display("FAIL reset_a_valid got=%0b want=0", a_valid); else passes++;
    checks++; if (a_ready !== 1'b1) $display("FAIL reset_a_ready got=%0b want=1", a_ready); else passes++;
    checks++; if (a_ctrl !== 8'h00) $display("FAIL reset_a_ctrl got=%02h want=00", a_ctrl); else passes++;
    checks++; if (a_data !== 32'h0) $display("FAIL reset_a_data got=%08h want=0", a_data); else passes++;
    checks++; if (a_occ !== 4'd0) $display("FAIL reset_a_occ got=%0d want=0", a_occ); else passes++;
    checks++; if (a_empty !== 1'b1) $display("FAIL reset_a_empty got=%0b want=1", a_empty); else passes++;
    checks++; if (b_valid !== 1'b0 || b_ready !== 1'b1 || b_ctrl !== 8'h00 || b_occ !== 4'd0)
      $display("FAIL reset_b got v=%0b r=%0b c=%02h o=%0d want v=0 r=1 c=00 o=0", b_valid, b_ready, b_ctrl, b_occ);
    else passes++;
  endtask

  // DEPTH=2 single item: visible one edge after acceptance.
  task automatic test_single();
    do_reset();
    ready = 1'b1; valid = 1'b1; ctrl = 8'h5A; data = 32'hDEAD_BEEF;
    tick();
    valid = 1'b0;
    checks++; if (a_s_ready !== 1'b1) $display("FAIL single_accept got=%0b want=1", a_s_ready); else passes++;
    checks++; if (a_valid !== 1'b0) $display("FAIL single_early_valid got=%0b want=0", a_valid); else passes++;
    tick();
    checks++; if (a_valid !== 1'b1 || a_ctrl !== 8'h5A || a_data !== 32'hDEAD_BEEF)
      $display("FAIL single_out got v=%0b c=%02h d=%08h want v=1 c=5a d=deadbeef", a_valid, a_ctrl, a_data);
    else passes++;
    checks++; if (a_occ !== 4'd1) $display("FAIL single_occ1 got=%0d want=1", a_occ); else passes++;
    tick();
    checks++; if (a_out_f !== 1'b1 || !a_pop_ok || a_s_ctrl !== a_exp.c || a_s_data !== a_exp.d)
      $display("FAIL single_deliver got f=%0b c=%02h d=%08h want f=1 c=%02h d=%08h", a_out_f, a_s_ctrl, a_s_data, a_exp.c, a_exp.d);
    else passes++;
    checks++; if (a_occ !== 4'd0 || a_valid !== 1'b0 || a_empty !== 1'b1)
      $display("FAIL single_drained got o=%0d v=%0b e=%0b want o=0 v=0 e=1", a_occ, a_valid, a_empty);
    else passes++;
  endtask

  // DEPTH=2 back-pressure: capacity 4, then drain in order.
  task automatic test_backpressure();
    int idx;
    int nout;
    do_reset();
    ready = 1'b0;
    idx = 1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      valid = (idx <= 6); ctrl = 8'(idx); data = 32'(idx) * 32'h1111;
      tick();
      if (a_in_f === 1'b1) idx++;
    end
    checks++; if (idx != 5) $display("FAIL bp_accepted got=%0d want=4", idx - 1); else passes++;
    checks++; if (a_ready !== 1'b0) $display("FAIL bp_ready got=%0b want=0", a_ready); else passes++;
    checks++; if (a_occ !== 4'd4) $display("FAIL bp_occ got=%0d want=4", a_occ); else passes++;
    ready = 1'b1;
    nout = 0;
    for (int cyc = 0; cyc < 20 && nout < 6; cyc++) begin
      valid = (idx <= 6); ctrl = 8'(idx); data = 32'(idx) * 32'h1111;
      tick();
      if (a_in_f === 1'b1) idx++;
      if (a_out_f === 1'b1) begin
        nout++;
        checks++;
        if (a_s_ctrl !== 8'(nout) || a_s_data !== 32'(nout) * 32'h1111)
          $display("FAIL bp_order got c=%02h d=%08h want c=%02h d=%08h", a_s_ctrl, a_s_data, 8'(nout), 32'(nout) * 32'h1111);
        else passes++;
        if (nout <= 4) begin
          checks++;
          if (cyc != nout - 1) $display("FAIL bp_consecutive item=%0d got_cycle=%0d want_cycle=%0d", nout, cyc, nout - 1);
          else passes++;
        end
      end
    end
    valid = 1'b0;
    checks++; if (nout != 6) $display("FAIL bp_count got=%0d want=6", nout); else passes++;
  endtask

  // DEPTH=1 full-rate streaming.
  task automatic test_stream();
    do_reset();
    ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      valid = (k < 10); ctrl = 8'(k); data = 32'(k);
      tick();
      if (k < 10) begin
        checks++; if (b_s_ready !== 1'b1) $display("FAIL stream_ready k=%0d got=%0b want=1", k, b_s_ready); else passes++;
      end
      if (k >= 1) begin
        checks++;
        if (b_s_valid !== 1'b1 || b_s_data !== 32'(k - 1))
          $display("FAIL stream_out k=%0d got v=%0b d=%0d want v=1 d=%0d", k, b_s_valid, b_s_data, k - 1);
        else passes++;
      end
      checks++; if (b_s_occ > 4'd1) $display("FAIL stream_occ k=%0d got=%0d want<=1", k, b_s_occ); else passes++;
    end
    valid = 1'b0;
  endtask

  // DEPTH=2 flush with 3 held while offering a 4th.
  task automatic test_flush();
    int seen;
    do_reset();
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid = 1'b1; ctrl = 8'h10 + 8'(k); data = $urandom;
      tick();
    end
    checks++; if (a_occ !== 4'd3) $display("FAIL flush_pre_occ got=%0d want=3", a_occ); else passes++;
    valid = 1'b1; ctrl = 8'h77; data = 32'h7777_7777; flush = 1'b1;
    tick();
    flush = 1'b0; valid = 1'b0;
    checks++; if (a_valid !== 1'b0 || a_ctrl !== 8'h00 || a_data !== 32'h0)
      $display("FAIL flush_out got v=%0b c=%02h d=%08h want v=0 c=00 d=0", a_valid, a_ctrl, a_data);
    else passes++;
    checks++; if (a_occ !== 4'd0 || a_ready !== 1'b1 || a_empty !== 1'b1)
      $display("FAIL flush_state got o=%0d r=%0b e=%0b want o=0 r=1 e=1", a_occ, a_ready, a_empty);
    else passes++;
    ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (a_out_f === 1'b1) seen++;
    end
    checks++; if (seen != 0) $display("FAIL flush_leak got=%0d want=0", seen); else passes++;
  endtask

  // DEPTH=2 freeze with 2 held.
  task automatic test_freeze();
    int nout;
    do_reset();
    ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      valid = 1'b1; ctrl = 8'h21 + 8'(k); data = 32'hA000_0000 + 32'(k);
      tick();
    end
    enable = 1'b0; valid = 1'b1; ready = 1'b1; ctrl = 8'h99; data = 32'h9999_9999;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (a_s_valid !== 1'b0 || a_s_ready !== 1'b0 || a_s_occ !== 4'd2 || a_s_ctrl !== 8'h21)
        $display("FAIL freeze k=%0d got v=%0b r=%0b o=%0d c=%02h want v=0 r=0 o=2 c=21", k, a_s_valid, a_s_ready, a_s_occ, a_s_ctrl);
      else passes++;
    end
    enable = 1'b1; valid = 1'b0;
    nout = 0;
    for (int k = 0; k < 10 && nout < 2; k++) begin
      tick();
      if (a_out_f === 1'b1) begin
        checks++;
        if (a_s_ctrl !== 8'h21 + 8'(nout) || a_s_data !== 32'hA000_0000 + 32'(nout))
          $display("FAIL freeze_order got c=%02h d=%08h want c=%02h d=%08h", a_s_ctrl, a_s_data, 8'h21 + 8'(nout), 32'hA000_0000 + 32'(nout));
        else passes++;
        nout++;
      end
    end
    checks++; if (nout != 2) $display("FAIL freeze_count got=%0d want=2", nout); else passes++;
  endtask

  // Reset mid-stream on the CLEAR_DATA=1 instance.
  task automatic test_reset_mid();
    bit got;
    do_reset();
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      valid = 1'b1; ctrl = 8'h40 + 8'(k); data = 32'h1234_0000 + 32'(k);
      tick();
    end
    reset = 1'b1; valid = 1'b1;
    tick();
    reset = 1'b0; valid = 1'b0;
    checks++; if (a_data !== 32'h0 || a_ctrl !== 8'h00 || a_valid !== 1'b0 || a_empty !== 1'b1)
      $display("FAIL rstmid got d=%08h c=%02h v=%0b e=%0b want d=0 c=00 v=0 e=1", a_data, a_ctrl, a_valid, a_empty);
    else passes++;
    valid = 1'b1; ctrl = 8'hC3; data = 32'h0BAD_F00D;
    tick();
    valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      tick();
      if (a_out_f === 1'b1) begin
        got = 1'b1;
        checks++;
        if (a_s_ctrl !== 8'hC3 || a_s_data !== 32'h0BAD_F00D)
          $display("FAIL rstmid_item got c=%02h d=%08h want c=c3 d=0badf00d", a_s_ctrl, a_s_data);
        else passes++;
      end
    end
    checks++; if (!got) $display("FAIL rstmid_timeout got=none want=item"); else passes++;
  endtask

  // Random traffic against the FIFO model, then a bounded drain.
  task automatic test_random();
    do_reset();
    for (int k = 0; k < 500; k++) begin
      enable = ($urandom_range(0, 15) != 0);
      flush  = ($urandom_range(0, 40) == 0);
      valid  = $urandom_range(0, 1);
      ready  = ($urandom_range(0, 3) != 0);
      ctrl   = 8'($urandom);
      data   = $urandom;
      tick();
      checks++;
      if (int'(a_s_occ) != a_occ_exp || a_s_occ > 4'd4 || a_s_empty !== (a_occ_exp == 0))
        $display("FAIL rand_a_occ k=%0d got o=%0d e=%0b want o=%0d", k, a_s_occ, a_s_empty, a_occ_exp);
      else passes++;
      checks++;
      if (int'(b_s_occ) != b_occ_exp || b_s_occ > 4'd2)
        $display("FAIL rand_b_occ k=%0d got o=%0d want o=%0d", k, b_s_occ, b_occ_exp);
      else passes++;
      if (!enable) begin
        checks++;
        if (a_s_ready !== 1'b0 || a_s_valid !== 1'b0 || b_s_ready !== 1'b0 || b_s_valid !== 1'b0)
          $display("FAIL rand_freeze k=%0d got ar=%0b av=%0b br=%0b bv=%0b want all 0", k, a_s_ready, a_s_valid, b_s_ready, b_s_valid);
        else passes++;
      end else begin
        if (a_occ_exp < 2) begin
          checks++;
          if (a_s_ready !== 1'b1) $display("FAIL rand_a_ready k=%0d got=%0b want=1", k, a_s_ready); else passes++;
        end
        checks++;
        if (b_s_valid !== (b_occ_exp > 0)) $display("FAIL rand_b_valid k=%0d got=%0b want=%0b", k, b_s_valid, b_occ_exp > 0);
        else passes++;
      end
      if (a_out_f === 1'b1) begin
        checks++;
        if (!a_pop_ok || a_s_ctrl !== a_exp.c || a_s_data !== a_exp.d)
          $display("FAIL rand_a_item k=%0d got c=%02h d=%08h want c=%02h d=%08h", k, a_s_ctrl, a_s_data, a_exp.c, a_exp.d);
        else passes++;
      end
      if (b_out_f === 1'b1) begin
        checks++;
        if (!b_pop_ok || b_s_ctrl !== b_exp.c || b_s_data !== b_exp.d)
          $display("FAIL rand_b_item k=%0d got c=%02h d=%08h want c=%02h d=%08h", k, b_s_ctrl, b_s_data, b_exp.c, b_exp.d);
        else passes++;
      end
    end
    flush = 1'b0; enable = 1'b1; valid = 1'b0; ready = 1'b1;
    for (int k = 0; k < 30 && (qa.size() > 0 || qb.size() > 0); k++) begin
      tick();
      if (a_out_f === 1'b1) begin
        checks++;
        if (!a_pop_ok || a_s_ctrl !== a_exp.c || a_s_data !== a_exp.d)
          $display("FAIL drain_a_item got c=%02h d=%08h want c=%02h d=%08h", a_s_ctrl, a_s_data, a_exp.c, a_exp.d);
        else passes++;
      end
    end
    checks++;
    if (qa.size() != 0 || qb.size() != 0 || a_occ !== 4'd0 || a_valid !== 1'b0)
      $display("FAIL drain_done got qa=%0d qb=%0d occ=%0d v=%0b want 0 0 0 0", qa.size(), qb.size(), a_occ, a_valid);
    else passes++;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b0;
    ctrl = '0; data = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_flush();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_pipe_elastic_reg
